// File: rtl/ofifo_psum_if.sv
// Handshake bundle between the MAC-array side and the output psum FIFO.
// The o_err status line exists only when OFIFO_ERR_EN is defined.
interface ofifo_psum_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16
);
   logic [col*psum_bw-1:0] in;
   logic [col-1:0]         wr;
   logic                   rd;
   logic [col*psum_bw-1:0] out;
   logic                   o_valid;
   logic                   o_full;
   logic                   o_ready;
`ifdef OFIFO_ERR_EN
   logic                   o_err;

   modport master (output in, wr, rd, input out, o_valid, o_full, o_ready, o_err);
   modport slave  (input in, wr, rd, output out, o_valid, o_full, o_ready, o_err);
`else
   modport master (output in, wr, rd, input out, o_valid, o_full, o_ready);
   modport slave  (input in, wr, rd, output out, o_valid, o_full, o_ready);
`endif
endinterface

// File: rtl/ofifo_psum.sv
// Per-column output FIFO for MAC psums; rows pop only when every column holds data.
// Define OFIFO_ERR_EN to add a sticky o_err flag for dropped writes and ignored reads.
module ofifo_psum #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic         clk,
   input  logic         reset,
   ofifo_psum_if.slave  bus
);

   localparam int AW = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]        wrPtr_q [col];
   logic [AW:0]        wrPtr_d [col];
   logic [AW:0]        rdPtr_q [col];
   logic [AW:0]        rdPtr_d [col];
   logic [psum_bw-1:0] mem_q   [col][depth];

   logic [col-1:0]         colEmpty;
   logic [col-1:0]         colFull;
   logic [col-1:0]         pushEn;
   logic                   allValid;
   logic                   popEn;
   logic [col*psum_bw-1:0] outRow;

   // The extra pointer MSB distinguishes a full column from an empty one
   always_comb begin
      colEmpty = '0;
      colFull  = '0;
      for (int i = 0; i < col; i++) begin
         colEmpty[i] = (wrPtr_q[i] == rdPtr_q[i]);
         colFull[i]  = (wrPtr_q[i][AW-1:0] == rdPtr_q[i][AW-1:0]) &&
                       (wrPtr_q[i][AW] != rdPtr_q[i][AW]);
      end
   end

   assign allValid    = ~|colEmpty;
   assign pushEn      = bus.wr & ~colFull;
   assign popEn       = bus.rd & allValid;
   assign bus.o_valid = allValid;
   assign bus.o_full  = |colFull;
   assign bus.o_ready = ~|colFull;

   always_comb begin
      for (int i = 0; i < col; i++) begin
         wrPtr_d[i] = wrPtr_q[i];
         rdPtr_d[i] = rdPtr_q[i];
         if (pushEn[i])
            wrPtr_d[i] = wrPtr_q[i] + PTR_ONE;
         if (popEn)
            rdPtr_d[i] = rdPtr_q[i] + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < col; i++) begin
            wrPtr_q[i] <= '0;
            rdPtr_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < col; i++) begin
            wrPtr_q[i] <= wrPtr_d[i];
            rdPtr_q[i] <= rdPtr_d[i];
         end
      end
   end

   // Storage is deliberately left unreset; the pointers alone define contents
   always_ff @(posedge clk) begin
      for (int i = 0; i < col; i++) begin
         if (pushEn[i])
            mem_q[i][wrPtr_q[i][AW-1:0]] <= bus.in[psum_bw*i +: psum_bw];
      end
   end

   always_comb begin
      outRow = '0;
      if (allValid) begin
         for (int i = 0; i < col; i++)
            outRow[psum_bw*i +: psum_bw] = mem_q[i][rdPtr_q[i][AW-1:0]];
      end
   end

   assign bus.out = outRow;

`ifdef OFIFO_ERR_EN
   logic err_q;
   logic err_d;

   assign err_d = err_q | (|(bus.wr & colFull)) | (bus.rd & ~allValid);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign bus.o_err = err_q;
`endif

endmodule

// File: tb/tb_ofifo_psum.sv
// Directed testbench for ofifo_psum with hand-computed expected rows.
// Checks o_err as well when built with OFIFO_ERR_EN.
module tb_ofifo_psum;

   logic clk;
   logic reset;
   int   totalChecks;
   int   badChecks;

   ofifo_psum_if #(.col(8), .psum_bw(16)) bus ();

   ofifo_psum #(.col(8), .psum_bw(16), .depth(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Row k carries k*16+i in lane i
   function automatic logic [127:0] rowVal(input int k);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         r[i*16 +: 16] = 16'(k*16 + i);
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge
   task automatic applyStimulus(input logic [7:0] w, input logic r, input logic [127:0] d);
      bus.in = d;
      bus.wr = w;
      bus.rd = r;
      @(posedge clk);
      #1;
      bus.wr = '0;
      bus.rd = 1'b0;
   endtask

   initial begin
      logic [127:0] expRow;
      totalChecks = 0;
      badChecks   = 0;
      bus.in = '0;
      bus.wr = '0;
      bus.rd = 1'b0;
      reset  = 1'b1;
      #2;
      checkOutput("rst_valid", bus.o_valid, 0);
      checkOutput("rst_full",  bus.o_full,  0);
      checkOutput("rst_ready", bus.o_ready, 1);
      checkOutput("rst_out",   bus.out,     0);
`ifdef OFIFO_ERR_EN
      checkOutput("rst_err",   bus.o_err,   0);
`endif
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] reset mid-fill");
      for (int k = 0; k < 10; k++)
         applyStimulus(8'hff, 1'b0, rowVal(k));
      checkOutput("fill10_valid", bus.o_valid, 1);
      checkOutput("fill10_out",   bus.out, rowVal(0));
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midrst_valid", bus.o_valid, 0);
      checkOutput("midrst_full",  bus.o_full,  0);
      checkOutput("midrst_ready", bus.o_ready, 1);
      checkOutput("midrst_out",   bus.out,     0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] skewed fill");
      applyStimulus(8'h7f, 1'b0, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
      checkOutput("skew_valid0", bus.o_valid, 0);
      checkOutput("skew_out0",   bus.out, 0);
      applyStimulus(8'h80, 1'b0, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
      checkOutput("skew_valid1", bus.o_valid, 1);
      checkOutput("skew_out1",   bus.out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
      applyStimulus(8'h00, 1'b1, '0);
      checkOutput("skew_pop_valid", bus.o_valid, 0);
`ifdef OFIFO_ERR_EN
      checkOutput("skew_err", bus.o_err, 0);
`endif

      $display("[TB] fill and wrap");
      for (int k = 0; k < 64; k++)
         applyStimulus(8'hff, 1'b0, rowVal(k));
      checkOutput("full_full",  bus.o_full,  1);
      checkOutput("full_ready", bus.o_ready, 0);
      checkOutput("full_valid", bus.o_valid, 1);
      applyStimulus(8'hff, 1'b0, rowVal(99));
      checkOutput("ovf_full", bus.o_full, 1);
`ifdef OFIFO_ERR_EN
      checkOutput("ovf_err", bus.o_err, 1);
`endif
      for (int k = 0; k < 64; k++) begin
         checkOutput($sformatf("drain_row%0d", k), bus.out, rowVal(k));
         applyStimulus(8'h00, 1'b1, '0);
      end
      checkOutput("drain_valid", bus.o_valid, 0);
      checkOutput("drain_full",  bus.o_full,  0);
      for (int k = 0; k < 3; k++)
         applyStimulus(8'hff, 1'b0, rowVal(40 + k));
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("wrap_row%0d", k), bus.out, rowVal(40 + k));
         applyStimulus(8'h00, 1'b1, '0);
      end
      checkOutput("wrap_valid", bus.o_valid, 0);

      $display("[TB] concurrent push and pop");
      for (int k = 0; k < 3; k++)
         applyStimulus(8'hff, 1'b0, rowVal(10 + k));
      checkOutput("conc_head", bus.out, rowVal(10));
      applyStimulus(8'hff, 1'b1, rowVal(13));
      for (int k = 1; k < 4; k++) begin
         checkOutput($sformatf("conc_row%0d", k), bus.out, rowVal(10 + k));
         applyStimulus(8'h00, 1'b1, '0);
      end
      checkOutput("conc_valid", bus.o_valid, 0);

      $display("[TB] underflow");
      #2;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(8'h00, 1'b1, '0);
         checkOutput($sformatf("under_out%0d", k), bus.out, 0);
      end
      checkOutput("under_valid", bus.o_valid, 0);
`ifdef OFIFO_ERR_EN
      checkOutput("under_err", bus.o_err, 1);
`endif
      applyStimulus(8'hff, 1'b0, rowVal(20));
      checkOutput("under_push_valid", bus.o_valid, 1);
      checkOutput("under_push_out",   bus.out, rowVal(20));
      applyStimulus(8'h00, 1'b1, '0);
      checkOutput("under_pop_valid", bus.o_valid, 0);

      $display("[TB] full column plus read");
      applyStimulus(8'hff, 1'b0, rowVal(30));
      for (int k = 0; k < 63; k++)
         applyStimulus(8'h01, 1'b0, rowVal(31 + k));
      checkOutput("fr_full",  bus.o_full,  1);
      checkOutput("fr_valid", bus.o_valid, 1);
      checkOutput("fr_head",  bus.out, rowVal(30));
      applyStimulus(8'h01, 1'b1, rowVal(200));
      checkOutput("fr_pop_valid", bus.o_valid, 0);
      checkOutput("fr_pop_full",  bus.o_full,  0);
      checkOutput("fr_pop_out",   bus.out, 0);
      applyStimulus(8'hfe, 1'b0, rowVal(50));
      expRow = rowVal(50);
      expRow[15:0] = 16'd496;
      checkOutput("fr_next_valid", bus.o_valid, 1);
      checkOutput("fr_next_out",   bus.out, expRow);
      checkOutput("fr_next_full",  bus.o_full, 0);

      $display("[TB] test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/ofifo_psum.md
Name: ofifo_psum

Overview:
- Output FIFO between the MAC array and psum SRAM / SFP inside the corelet.
- One independent FIFO per MAC column; each column pushes its psum when its own valid strobe fires.
- A full row pops only when every column has data, so drained words are column-aligned.
- `o_valid` drives the core's `ofifo_valid` and gates psum SRAM writes.

Parameters:
- `col`, 8, number of MAC columns, i.e. lanes.
- `psum_bw`, 16, width of one psum lane in bits.
- `depth`, 64, entries per column FIFO; must be a power of 2 and at least 2.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in`  input  col*psum_bw  psum lanes; lane i is `in[psum_bw*(i+1)-1 : psum_bw*i]`.
- `wr`  input  col  per-column push strobe.
- `rd`  input  1  row pop request.
- `out`  output  col*psum_bw  head row, same lane packing as `in`.
- `o_valid`  output  1  every column non-empty.
- `o_full`  output  1  any column full.
- `o_ready`  output  1  equals `~o_full`.

Behaviour:
- Reset (asynchronous, active-high):
  - All read/write pointers go to 0.
  - Outputs: `o_valid`=0, `o_full`=0, `o_ready`=1, `out`=0.
  - Storage array is not reset.
  - Reset asserted mid-stream discards all contents immediately, without waiting for a clock edge.
- Per-column storage:
  - `depth` x `psum_bw` entries.
  - Write and read pointers are log2(depth)+1 bits; the extra MSB is the wrap bit.
- Empty/full per column i:
  - `empty_i` when the pointers are equal.
  - `full_i` when the low bits are equal and the MSBs differ.
- Flags, combinational from registered pointers:
  - `o_valid` = AND of `~empty_i` over all columns.
  - `o_full` = OR of `full_i` over all columns.
- Push: on a rising edge with `wr[i]`=1 and `full_i`=0, store lane i at `wptr_i` and increment `wptr_i`.
  - `wr[i]` while `full_i`=1 drops the data; the pointer is unchanged.
  - A full column stays full and drops the write even if `rd` pops in the same cycle.
- Pop: on a rising edge with `rd`=1 and `o_valid`=1, increment every `rptr_i`.
  - `rd` while `o_valid`=0 is ignored; no pointer moves.
- Read latency (first-word fall-through):
  - `out` is the head entry of every column, combinationally from storage at `rptr`, whenever `o_valid`=1.
  - `out` is forced to all-zero when `o_valid`=0.
  - After a pop, `out` shows the next row in the following cycle.
- Write latency: a push at edge N can make `o_valid` rise in the cycle after edge N. No bypass from `in` to `out`.
- Simultaneous push and pop on a non-full column: both take effect and occupancy is unchanged.
  - A push into an empty column alongside `rd` pops nothing, because `o_valid` was 0.
- Pointer wrap: after `depth` pushes the low bits return to 0 and the MSB toggles. Ordering is preserved across the wrap.
- Columns are fully independent: columns may be skewed by any number of entries, up to `depth`.

Optional Feature:
- Macro: `OFIFO_ERR_EN`.
- With the macro defined:
  - Extra output port `o_err` (1 bit), reset to 0.
  - Sticky set on the rising edge of any dropped write (`wr[i]` && `full_i`) or any ignored read (`rd` && !`o_valid`).
  - Cleared only by `reset`.
- Without the macro: no `o_err` port and no added logic; all other behaviour is identical.

Test Plan:
- Reset → `o_valid`=0, `o_full`=0, `o_ready`=1, `out`=0. Assert `reset` mid-fill of 10 rows → flags return to reset values in the same cycle.
- Skewed fill:
  - Push lane i = 0x0100+i on all columns except column 7 → `o_valid` stays 0.
  - Push column 7 = 0x0107 → next cycle `o_valid`=1 and `out` lanes = 0x0100..0x0107.
  - `rd` → `o_valid`=0.
- Fill and wrap:
  - Push 64 rows (row k, lane i = k*16+i) → `o_full`=1, `o_ready`=0.
  - A 65th push is dropped; with `OFIFO_ERR_EN`, `o_err`=1.
  - Pop 64 rows → values arrive in order k=0..63, then `o_valid`=0.
  - Refill across the wrap → order preserved.
- Concurrent: with 3 rows queued, push a 4th row and `rd` in the same cycle → occupancy stays 3, and the popped row is row 0.
- Underflow: `rd` held high while empty for 5 cycles → pointers unchanged, `out`=0. With `OFIFO_ERR_EN`, `o_err`=1; a subsequent valid push/pop works normally.
- Full plus read: column 0 full and others holding 1 row, then `wr[0]` and `rd` together → column 0 write dropped, and one row popped from every column.
